// File: rtl/full_sub_if.sv
// Operand/result bundle for the registered full subtractor.
// The ovf signal exists only when FULL_SUB_OVF_EN is defined.
interface full_sub_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             out_valid;
`ifdef FULL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, A, B, C,
    input  D, Bout, out_valid, ovf
  );

  modport slave (
    input  in_valid, A, B, C,
    output D, Bout, out_valid, ovf
  );
`else
  modport master (
    output in_valid, A, B, C,
    input  D, Bout, out_valid
  );

  modport slave (
    input  in_valid, A, B, C,
    output D, Bout, out_valid
  );
`endif
endinterface

// File: rtl/full_sub.sv
// Registered WIDTH-bit full subtractor {Bout,D} = A - B - C with one-cycle latency.
// Defining FULL_SUB_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module full_sub #(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  full_sub_if.slave   bus
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             valid_q;

  // Ripple-borrow chain; br[0] is the borrow-in, br[WIDTH] the borrow-out.
  assign br[0] = bus.C;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i]  = bus.A[i] ^ bus.B[i] ^ br[i];
    assign br[i+1]  = (~bus.A[i] & bus.B[i]) | (~bus.A[i] & br[i]) | (bus.B[i] & br[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q     <= '0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        d_q    <= diff;
        bout_q <= br[WIDTH];
      end
    end
  end

  assign bus.D         = d_q;
  assign bus.Bout      = bout_q;
  assign bus.out_valid = valid_q;

`ifdef FULL_SUB_OVF_EN
  logic ovf_next;
  logic ovf_q;

  // Signed overflow is only possible when the operand signs differ.
  assign ovf_next = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= ovf_next;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_sub.sv
// Scoreboard bench for full_sub at WIDTH 1, 8 and 16 driven side by side.
// Define FULL_SUB_OVF_EN to also check the overflow flag.
module tb_full_sub;

`ifdef FULL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst_seen;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  exp_t q1[$];
  exp_t q8[$];
  exp_t q16[$];
  exp_t held1, held8, held16;

  full_sub_if #(.WIDTH(1))  bus1 ();
  full_sub_if #(.WIDTH(8))  bus8 ();
  full_sub_if #(.WIDTH(16)) bus16 ();

  full_sub #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  full_sub #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  full_sub #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t m;
    int   mask, ua, ub, full, sa, sb, sv, lim;
    mask   = (1 << w) - 1;
    ua     = int'(a) & mask;
    ub     = int'(b) & mask;
    full   = ua - ub - int'(c);
    m.due  = 0;
    m.d    = 16'(full) & 16'(mask);
    m.bout = (full < 0);
    sa     = a[w-1] ? ua - (1 << w) : ua;
    sb     = b[w-1] ? ub - (1 << w) : ub;
    sv     = sa - sb - int'(c);
    lim    = 1 << (w - 1);
    m.ovf  = (sv < -lim) || (sv > lim - 1);
    return m;
  endfunction

  task automatic drv(input int w, input logic [15:0] a, input logic [15:0] b, input logic c,
                     input logic [15:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.due  = cyc + 1;
    e.d    = ed;
    e.bout = eb;
    e.ovf  = eo;
    case (w)
      1: begin
        bus1.in_valid = 1'b1; bus1.A = a[0]; bus1.B = b[0]; bus1.C = c;
        if (rst_n) q1.push_back(e);
      end
      8: begin
        bus8.in_valid = 1'b1; bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.C = c;
        if (rst_n) q8.push_back(e);
      end
      default: begin
        bus16.in_valid = 1'b1; bus16.A = a; bus16.B = b; bus16.C = c;
        if (rst_n) q16.push_back(e);
      end
    endcase
  endtask

  // Directed vector: D/Bout given explicitly, ovf taken from the reference.
  task automatic drv_dir(input int w, input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] ed, input logic eb);
    exp_t m;
    m = model(w, a, b, c);
    drv(w, a, b, c, ed, eb, m.ovf);
  endtask

  task automatic drv_rand(input int w);
    exp_t        m;
    logic [15:0] a, b;
    logic        c;
    a = 16'($urandom);
    b = 16'($urandom);
    c = 1'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      a = '0;
      b = 16'hffff;
    end
    m = model(w, a, b, c);
    drv(w, a, b, c, m.d, m.bout, m.ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus1.in_valid  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus16.in_valid = 1'b0;
  endtask

  task automatic check_out(input string nm, input logic vld, input logic [15:0] d, input logic bo,
                           input logic ov, input bit have, input exp_t e, input exp_t held);
    bit ok;
    ok = 1'b1;
    n_total++;
    if (vld) begin
      if (!have) begin
        ok = 1'b0;
        $display("FAIL %s unexpected out_valid: got d=%h bout=%b, required no result", nm, d, bo);
      end else if (e.due != cyc || d != e.d || bo != e.bout || (OVF_EN && ov != e.ovf)) begin
        ok = 1'b0;
        $display("FAIL %s result: got cyc=%0d d=%h bout=%b ovf=%b, required cyc=%0d d=%h bout=%b ovf=%b",
                 nm, cyc, d, bo, ov, e.due, e.d, e.bout, e.ovf);
      end
    end else begin
      if (have && e.due <= cyc) begin
        ok = 1'b0;
        $display("FAIL %s missing out_valid: got 0 at cyc=%0d, required 1 (due %0d)", nm, cyc, e.due);
      end else if (d != held.d || bo != held.bout || (OVF_EN && ov != held.ovf)) begin
        ok = 1'b0;
        $display("FAIL %s hold: got d=%h bout=%b ovf=%b, required d=%h bout=%b ovf=%b",
                 nm, d, bo, ov, held.d, held.bout, held.ovf);
      end
    end
    if (ok) n_pass++;
  endtask

  task automatic check_reset(input string nm, input logic vld, input logic [15:0] d, input logic bo,
                             input logic ov);
    n_total++;
    if (vld || d != 16'h0 || bo || (OVF_EN && ov)) begin
      $display("FAIL %s reset: got out_valid=%b d=%h bout=%b ovf=%b, required all 0", nm, vld, d, bo, ov);
    end else begin
      n_pass++;
    end
  endtask

  logic ovf1, ovf8, ovf16;
`ifdef FULL_SUB_OVF_EN
  assign ovf1  = bus1.ovf;
  assign ovf8  = bus8.ovf;
  assign ovf16 = bus16.ovf;
`else
  assign ovf1  = 1'b0;
  assign ovf8  = 1'b0;
  assign ovf16 = 1'b0;
`endif

  // Monitor: samples on the falling edge, pops one expectation per out_valid.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    exp_t zero;
    zero = '{due: 0, d: 16'h0, bout: 1'b0, ovf: 1'b0};
    if (!rst_seen) begin
      check_reset("w1",  bus1.out_valid,  16'(bus1.D),  bus1.Bout,  ovf1);
      check_reset("w8",  bus8.out_valid,  16'(bus8.D),  bus8.Bout,  ovf8);
      check_reset("w16", bus16.out_valid, bus16.D,      bus16.Bout, ovf16);
      held1 = zero; held8 = zero; held16 = zero;
    end else begin
      have = (q1.size() > 0);
      e    = have ? q1[0] : zero;
      check_out("w1", bus1.out_valid, 16'(bus1.D), bus1.Bout, ovf1, have, e, held1);
      if (bus1.out_valid && have) begin held1 = e; void'(q1.pop_front()); end

      have = (q8.size() > 0);
      e    = have ? q8[0] : zero;
      check_out("w8", bus8.out_valid, 16'(bus8.D), bus8.Bout, ovf8, have, e, held8);
      if (bus8.out_valid && have) begin held8 = e; void'(q8.pop_front()); end

      have = (q16.size() > 0);
      e    = have ? q16[0] : zero;
      check_out("w16", bus16.out_valid, bus16.D, bus16.Bout, ovf16, have, e, held16);
      if (bus16.out_valid && have) begin held16 = e; void'(q16.pop_front()); end
    end
  end

  initial begin
    logic [7:0] tt_d;
    logic [7:0] tt_b;
    logic [2:0] abc;
    tt_d = 8'b1001_0110;
    tt_b = 8'b1000_1110;

    rst_n = 1'b0;
    bus1.in_valid  = 1'b0; bus1.A  = '0; bus1.B  = '0; bus1.C  = 1'b0;
    bus8.in_valid  = 1'b0; bus8.A  = '0; bus8.B  = '0; bus8.C  = 1'b0;
    bus16.in_valid = 1'b0; bus16.A = '0; bus16.B = '0; bus16.C = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // WIDTH=1 truth table, one vector every 10 cycles
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      drv_dir(1, {15'h0, abc[2]}, {15'h0, abc[1]}, abc[0], {15'h0, tt_d[i]}, tt_b[i]);
      repeat (10) tick();
    end

    // back-to-back pair at WIDTH=8
    drv_dir(8, 16'h0050, 16'h0020, 1'b1, 16'h002f, 1'b0);
    tick();
    drv_dir(8, 16'h0000, 16'h00ff, 1'b1, 16'h0000, 1'b1);
    tick();
    tick();

    // idle with garbage operands
    bus8.A  = 'x; bus8.B  = 'x; bus8.C  = 1'bx;
    bus16.A = 16'($urandom); bus16.B = 16'($urandom); bus16.C = 1'b1;
    repeat (5) tick();

    drv_dir(8, 16'h003c, 16'h003c, 1'b0, 16'h0000, 1'b0);
    drv_dir(16, 16'h0000, 16'hffff, 1'b1, 16'h0000, 1'b1);
    tick();
    drv_dir(1, 16'h0000, 16'h0001, 1'b1, 16'h0000, 1'b1);
    tick();
    tick();

    if (OVF_EN) begin
      drv(8, 16'h0080, 16'h0001, 1'b0, 16'h007f, 1'b0, 1'b1);
      tick();
      drv(8, 16'h007f, 16'h00ff, 1'b0, 16'h0080, 1'b1, 1'b1);
      tick();
      drv(8, 16'h0010, 16'h0001, 1'b0, 16'h000f, 1'b0, 1'b0);
      tick();
      tick();
    end

    // reset on the same edge as a valid vector discards it
    rst_n = 1'b0;
    drv_dir(8, 16'h0005, 16'h0001, 1'b0, 16'h0004, 1'b0);
    tick();
    rst_n = 1'b1;
    drv_dir(8, 16'h0005, 16'h0001, 1'b0, 16'h0004, 1'b0);
    tick();
    tick();

    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 4) != 0) drv_rand(1);
      if ($urandom_range(0, 4) != 0) drv_rand(8);
      if ($urandom_range(0, 4) != 0) drv_rand(16);
      tick();
    end
    repeat (3) tick();

    n_total++;
    if (q1.size() != 0 || q8.size() != 0 || q16.size() != 0) begin
      $display("FAIL drain: got pending w1=%0d w8=%0d w16=%0d, required 0", q1.size(), q8.size(), q16.size());
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
